// File: rtl/bus_share_arbiter.sv
// Round-robin arbiter that lends one shared output register to NREQ requester lanes, one burst per grant.
// Optional beat limit per grant: define BUS_ARB_BURST_LIMIT_EN (limit set by MAX_BURST).
module bus_share_arbiter #(
    parameter int NREQ      = 2,
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*DW-1:0] req_data,
    input  logic [NREQ-1:0]    req_last,
    output logic [NREQ-1:0]    req_ready,
    output logic [NREQ-1:0]    grant,
    output logic               out_valid,
    output logic [DW-1:0]      out_data,
    input  logic               out_ready,
    output logic               busy,
    output logic               flag
);

    localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {
        ST_IDLE,
        ST_BURST
    } state_e;

    state_e            state_q, state_d;
    logic [OW-1:0]     owner_q, owner_d;
    logic [OW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic              out_valid_q, out_valid_d;
    logic [DW-1:0]     out_data_q, out_data_d;

    logic [OW-1:0]     pick;
    logic              found;
    logic [OW-1:0]     owner_next;
    logic              beat;
    logic              owner_last;
    logic              limit_hit;

    // The owner may push a new beat whenever the register is empty or is being drained this cycle.
    assign req_ready  = grant_q & {NREQ{~out_valid_q | out_ready}};
    assign beat       = req_valid[owner_q] & req_ready[owner_q];
    assign owner_last = req_last[owner_q];
    assign owner_next = (owner_q == OW'(NREQ - 1)) ? '0 : owner_q + 1'b1;

    // First requesting lane at or above rr_ptr, wrapping around.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req_valid[(int'(rr_ptr_q) + k) % NREQ]) begin
                found = 1'b1;
                pick  = OW'((int'(rr_ptr_q) + k) % NREQ);
            end
        end
    end

`ifdef BUS_ARB_BURST_LIMIT_EN
    localparam int CW = $clog2(MAX_BURST + 1);

    logic [CW-1:0] burst_cnt_q, burst_cnt_d;
    logic          flag_q, flag_d;

    assign limit_hit = ((burst_cnt_q + 1'b1) == CW'(MAX_BURST));

    // Holding the count at zero while idle is what clears it on entry to a burst.
    always_comb begin
        burst_cnt_d = burst_cnt_q;
        flag_d      = 1'b0;
        if (state_q == ST_IDLE) begin
            burst_cnt_d = '0;
        end else if (beat) begin
            burst_cnt_d = burst_cnt_q + 1'b1;
            flag_d      = limit_hit & ~owner_last;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst_cnt_q <= '0;
            flag_q      <= 1'b0;
        end else begin
            burst_cnt_q <= burst_cnt_d;
            flag_q      <= flag_d;
        end
    end

    assign flag = flag_q;
`else
    logic unused_max_burst;

    assign limit_hit        = 1'b0;
    assign flag             = 1'b0;
    assign unused_max_burst = (MAX_BURST > 0);
`endif

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    state_d = ST_BURST;
                    owner_d = pick;
                    grant_d = NREQ'(1) << pick;
                end
            end
            ST_BURST: begin
                if (beat && (owner_last || limit_hit)) begin
                    state_d  = ST_IDLE;
                    grant_d  = '0;
                    rr_ptr_d = owner_next;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A drain and a new beat in the same cycle keeps the register full with fresh data.
        if (beat) begin
            out_valid_d = 1'b1;
            out_data_d  = req_data[owner_q*DW +: DW];
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the data register is reset too, so a burst cut short by reset leaves nothing visible.
            state_q     <= ST_IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign grant     = grant_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = (state_q != ST_IDLE) | out_valid_q;

endmodule

// File: tb/tb_bus_share_arbiter.sv
// Self-checking bench for bus_share_arbiter: directed scenarios then random traffic, checked
// every cycle against a lane/owner reference model built from the arbitration rules.
module tb_bus_share_arbiter;

    localparam int NREQ      = 2;
    localparam int DW        = 8;
    localparam int MAX_BURST = 4;
`ifdef BUS_ARB_BURST_LIMIT_EN
    localparam bit LIMIT = 1'b1;
`else
    localparam bit LIMIT = 1'b0;
`endif

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [15:0] req_data  = '0;
    logic [1:0]  req_last  = '0;
    logic [1:0]  req_ready;
    logic [1:0]  grant;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready = 1'b0;
    logic        busy;
    logic        flag;

    bus_share_arbiter #(.NREQ(NREQ), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .grant     (grant),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy),
        .flag      (flag)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: owner is a lane number or -1 when nobody holds the bus.
    int         m_owner, m_rr, m_cnt;
    bit         m_ov, m_flag;
    logic [7:0] m_od;
    int         p_owner, p_rr, p_cnt;
    bit         p_ov, p_flag;
    logic [7:0] p_od;

    logic [1:0] beat_vec;
    logic [1:0] prev_grant;
    int         g0_rises, g1_rises, flag_cnt;
    logic [1:0] rr_seq [8];

    task automatic model_reset();
        m_owner = -1; m_rr = 0; m_cnt = 0; m_ov = 0; m_flag = 0; m_od = '0;
    endtask

    function automatic logic [1:0] m_grant();
        return (m_owner < 0) ? 2'b00 : 2'(1 << m_owner);
    endfunction

    function automatic logic [1:0] m_ready();
        logic [1:0] r = '0;
        if (m_owner >= 0 && (!m_ov || out_ready)) r[m_owner] = 1'b1;
        return r;
    endfunction

    task automatic model_predict();
        bit took = 0;
        p_owner = m_owner; p_rr = m_rr; p_cnt = m_cnt; p_ov = m_ov; p_od = m_od; p_flag = 0;
        if (m_owner < 0) begin
            for (int k = 0; k < NREQ; k++) begin
                int idx = (m_rr + k) % NREQ;
                if (p_owner < 0 && req_valid[idx]) begin
                    p_owner = idx;
                    p_cnt   = 0;
                end
            end
        end else if (req_valid[m_owner] && (!m_ov || out_ready)) begin
            took  = 1;
            p_ov  = 1;
            p_od  = req_data[m_owner*DW +: DW];
            p_cnt = m_cnt + 1;
            if (req_last[m_owner] || (LIMIT && p_cnt == MAX_BURST)) begin
                p_owner = -1;
                p_rr    = (m_owner + 1) % NREQ;
                p_flag  = !req_last[m_owner];
            end
        end
        if (!took && out_ready) p_ov = 0;
    endtask

    task automatic model_commit();
        m_owner = p_owner; m_rr = p_rr; m_cnt = p_cnt; m_ov = p_ov; m_od = p_od; m_flag = p_flag;
    endtask

    // One clock with the inputs the caller has just set.
    task automatic step(input string tag);
        #1;
        check({tag, ".ready"}, 32'(req_ready), 32'(m_ready()));
        beat_vec = req_valid & req_ready;
        model_predict();
        @(posedge clk);
        #1;
        model_commit();
        if (grant[0] && !prev_grant[0]) g0_rises++;
        if (grant[1] && !prev_grant[1]) g1_rises++;
        if (flag) flag_cnt++;
        prev_grant = grant;
        check({tag, ".grant"},     32'(grant),     32'(m_grant()));
        check({tag, ".out_valid"}, 32'(out_valid), 32'(m_ov));
        check({tag, ".out_data"},  32'(out_data),  32'(m_od));
        check({tag, ".busy"},      32'(busy),      32'((m_owner >= 0) || m_ov));
        check({tag, ".flag"},      32'(flag),      32'(m_flag));
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".grant"},     32'(grant),     32'h0);
        check({tag, ".ready"},     32'(req_ready), 32'h0);
        check({tag, ".out_valid"}, 32'(out_valid), 32'h0);
        check({tag, ".out_data"},  32'(out_data),  32'h0);
        check({tag, ".busy"},      32'(busy),      32'h0);
        check({tag, ".flag"},      32'(flag),      32'h0);
    endtask

    initial begin
        int  ov_cnt;
        int  acc;
        int  l1;
        bit  l0_done;

        model_reset();
        prev_grant = '0;
        g0_rises = 0; g1_rises = 0; flag_cnt = 0;
        rr_seq = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};

        @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;

        // Round robin with single-beat bursts.
        req_valid = 2'b11; req_last = 2'b11; req_data = {8'h3C, 8'hA5}; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step("rr");
            check("rr.seq", 32'(grant), 32'(rr_seq[i]));
            if (i == 1) check("rr.data0", 32'(out_data), 32'hA5);
            if (i == 3) check("rr.data1", 32'(out_data), 32'h3C);
        end

        // Backpressure on a 3-beat lane 0 burst.
        req_valid = 2'b01; req_last = 2'b00; req_data[7:0] = 8'h11;
        step("bp");
        step("bp");
        check("bp.first", 32'(out_data), 32'h11);
        req_data[7:0] = 8'h22; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step("bp_hold");
            check("bp.hold", 32'(out_data), 32'h11);
            check("bp.noready", 32'(req_ready), 32'h0);
        end
        out_ready = 1'b1;
        step("bp");
        check("bp.second", 32'(out_data), 32'h22);
        req_data[7:0] = 8'h33; req_last = 2'b01;
        step("bp");
        check("bp.third", 32'(out_data), 32'h33);
        check("bp.release", 32'(grant), 32'h0);
        req_valid = 2'b00; req_last = 2'b00;
        step("bp_drain");
        check("bp.drained", 32'(out_valid), 32'h0);

        // Full throughput: 4-beat lane 1 burst.
        req_valid = 2'b10; req_data[15:8] = 8'hB0;
        step("ft");
        ov_cnt = 0; acc = 0;
        for (int i = 0; i < 4; i++) begin
            req_data[15:8] = 8'(8'hB0 + i);
            req_last = (i == 3) ? 2'b10 : 2'b00;
            step("ft");
            acc    += int'(beat_vec[1]);
            ov_cnt += int'(out_valid);
        end
        req_valid = 2'b00; req_last = 2'b00;
        step("ft_tail");
        ov_cnt += int'(out_valid);
        check("ft.beats", 32'(acc), 32'd4);
        check("ft.ov_cycles", 32'(ov_cnt), 32'd4);

        // Six-beat lane 1 burst competing with a one-beat lane 0 request.
        g0_rises = 0; g1_rises = 0; flag_cnt = 0; l1 = 0; l0_done = 0;
        req_valid = 2'b10; req_last = 2'b00; req_data[15:8] = 8'hC1;
        step("lim");
        for (int i = 0; i < 20; i++) begin
            req_valid = {l1 < 6, !l0_done};
            req_last  = {l1 == 5, 1'b1};
            req_data  = {8'(8'hC1 + l1), 8'h0D};
            step("lim");
            if (beat_vec[1]) l1++;
            if (beat_vec[0]) l0_done = 1;
        end
        req_valid = 2'b00; req_last = 2'b00;
        step("lim_tail");
        check("lim.l1_beats", 32'(l1), 32'd6);
        check("lim.l0_done", 32'(l0_done), 32'd1);
        check("lim.flags", 32'(flag_cnt), LIMIT ? 32'd1 : 32'd0);
        check("lim.l1_grants", 32'(g1_rises), LIMIT ? 32'd2 : 32'd1);
        check("lim.l0_grants", 32'(g0_rises), 32'd1);

        // Owner stalls mid-burst while lane 1 waits.
        req_valid = 2'b01; req_last = 2'b00; req_data[7:0] = 8'h5A;
        step("stall");
        step("stall");
        req_valid = 2'b10;
        for (int i = 0; i < 5; i++) begin
            step("stall_hold");
            check("stall.grant", 32'(grant), 32'h1);
            check("stall.busy", 32'(busy), 32'h1);
        end
        req_valid = 2'b11; req_last = 2'b01; req_data = {8'h6B, 8'h5B};
        step("stall_resume");
        check("stall.resume_data", 32'(out_data), 32'h5B);
        step("stall_next");
        check("stall.next_owner", 32'(grant), 32'h2);
        req_last = 2'b11;
        step("stall_next");
        req_valid = 2'b00; req_last = 2'b00;
        step("stall_tail");
        step("stall_tail");

        // Random traffic.
        for (int i = 0; i < 500; i++) begin
            req_valid   = 2'($urandom);
            req_last[0] = ($urandom_range(0, 3) == 0);
            req_last[1] = ($urandom_range(0, 3) == 0);
            req_data    = 16'($urandom);
            out_ready   = ($urandom_range(0, 3) != 0);
            step("rand");
        end

        // Reset in the middle of a lane 1 burst holding data.
        req_valid = 2'b00; req_last = 2'b00; out_ready = 1'b1;
        step("pre_rst");
        step("pre_rst");
        req_valid = 2'b01; req_last = 2'b01; req_data[7:0] = 8'h77;
        step("pre_rst");
        step("pre_rst");
        req_valid = 2'b10; req_last = 2'b00; req_data[15:8] = 8'h88; out_ready = 1'b0;
        step("pre_rst");
        step("pre_rst");
        check("pre_rst.held", 32'(out_valid), 32'h1);
        req_valid = 2'b11;
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("rst_async");
        model_reset();
        @(posedge clk);
        #1;
        check_zero("rst_hold");
        prev_grant = '0;
        out_ready = 1'b1;
        rst_n = 1'b1;
        step("rst_rel");
        check("rst_rel.first_grant", 32'(grant), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
